// File: rtl/fp16_operand_unpack.sv
// Two-stage binary16 operand unpacker feeding the half-precision add/sub datapath.
// Optional build macro FP16_UNPACK_DAZ_EN flushes subnormal inputs to signed zero.
module fp16_operand_unpack #(
  parameter int EXP_W  = 5,
  parameter int MANT_W = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EXP_W+MANT_W:0] A,
  input  logic [EXP_W+MANT_W:0] B,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  SIGN_A,
  output logic                  SIGN_B,
  output logic [EXP_W-1:0]      IN_EXP_A_HALF,
  output logic [EXP_W-1:0]      IN_EXP_B_HALF,
  output logic [EXP_W-1:0]      IN_EXP_HALF,
  output logic [MANT_W:0]       IN_MANT_A_HALF,
  output logic [MANT_W:0]       IN_MANT_B_HALF,
  output logic [EXP_W-1:0]      EXP_DIFF,
  output logic                  A_GE_B,
  output logic [3:0]            CLASS_A,
  output logic [3:0]            CLASS_B
);

  // Handshake: a pair moves on input when in_valid && in_ready and leaves on
  // output when out_valid && out_ready; in_ready depends only on stage state
  // and out_ready, and stage-2 data holds while out_valid && !out_ready.

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W:0]   mant;
    logic [3:0]        cls;   // {nan, inf, sub, zero}
  } op_t;

  function automatic op_t decode(input logic [EXP_W+MANT_W:0] x);
    logic [EXP_W-1:0]  e;
    logic [MANT_W-1:0] f;
    op_t               o;
    e      = x[MANT_W +: EXP_W];
    f      = x[MANT_W-1:0];
    o.sign = x[EXP_W+MANT_W];
    o.exp  = (e == '0) ? EXP_W'(1) : e;
    o.mant = {(e != '0), f};
    o.cls  = {(e == '1) && (f != '0), (e == '1) && (f == '0),
              (e == '0) && (f != '0), (e == '0) && (f == '0)};
`ifdef FP16_UNPACK_DAZ_EN
    if (e == '0) begin
      o.mant = '0;
      o.cls  = 4'b0001;
    end
`endif
    return o;
  endfunction

  logic s1_valid_q;
  op_t  s1_a_q, s1_b_q;
  op_t  s1_a_d, s1_b_d;

  logic             s2_valid_q;
  op_t              s2_a_q, s2_b_q;
  logic             s2_ge_q, s2_ge_d;
  logic [EXP_W-1:0] s2_exp_q, s2_exp_d;
  logic [EXP_W-1:0] s2_diff_q, s2_diff_d;

  logic s2_accept;

  assign s2_accept = !s2_valid_q || out_ready;
  assign in_ready  = !s1_valid_q || s2_accept;

  assign s1_a_d = decode(A);
  assign s1_b_d = decode(B);

  always_comb begin
    s2_ge_d   = (s1_a_q.exp >= s1_b_q.exp);
    s2_exp_d  = s2_ge_d ? s1_a_q.exp : s1_b_q.exp;
    s2_diff_d = s2_ge_d ? (s1_a_q.exp - s1_b_q.exp) : (s1_b_q.exp - s1_a_q.exp);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_a_q <= s1_a_d;
        s1_b_q <= s1_b_d;
      end
    end
  end

  // Stage 2 only loads when it is empty or draining, so a held result never changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_a_q     <= '0;
      s2_b_q     <= '0;
      s2_ge_q    <= 1'b0;
      s2_exp_q   <= '0;
      s2_diff_q  <= '0;
    end else if (s2_accept) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_a_q    <= s1_a_q;
        s2_b_q    <= s1_b_q;
        s2_ge_q   <= s2_ge_d;
        s2_exp_q  <= s2_exp_d;
        s2_diff_q <= s2_diff_d;
      end
    end
  end

  assign out_valid      = s2_valid_q;
  assign SIGN_A         = s2_a_q.sign;
  assign SIGN_B         = s2_b_q.sign;
  assign IN_EXP_A_HALF  = s2_a_q.exp;
  assign IN_EXP_B_HALF  = s2_b_q.exp;
  assign IN_EXP_HALF    = s2_exp_q;
  assign IN_MANT_A_HALF = s2_a_q.mant;
  assign IN_MANT_B_HALF = s2_b_q.mant;
  assign EXP_DIFF       = s2_diff_q;
  assign A_GE_B         = s2_ge_q;
  assign CLASS_A        = s2_a_q.cls;
  assign CLASS_B        = s2_b_q.cls;

endmodule

// File: tb/tb_fp16_operand_unpack.sv
// Directed bench for fp16_operand_unpack: field decode, handshake, backpressure,
// full throughput and asynchronous reset with pairs in flight.
module tb_fp16_operand_unpack;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A, B;
  logic        out_valid;
  logic        out_ready;
  logic        SIGN_A, SIGN_B;
  logic [4:0]  IN_EXP_A_HALF, IN_EXP_B_HALF, IN_EXP_HALF, EXP_DIFF;
  logic [10:0] IN_MANT_A_HALF, IN_MANT_B_HALF;
  logic        A_GE_B;
  logic [3:0]  CLASS_A, CLASS_B;

  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q[$];

  fp16_operand_unpack dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .SIGN_A(SIGN_A), .SIGN_B(SIGN_B),
    .IN_EXP_A_HALF(IN_EXP_A_HALF), .IN_EXP_B_HALF(IN_EXP_B_HALF),
    .IN_EXP_HALF(IN_EXP_HALF), .IN_MANT_A_HALF(IN_MANT_A_HALF),
    .IN_MANT_B_HALF(IN_MANT_B_HALF), .EXP_DIFF(EXP_DIFF), .A_GE_B(A_GE_B),
    .CLASS_A(CLASS_A), .CLASS_B(CLASS_B)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag,
                         input logic sa, input logic sb,
                         input logic [4:0] ea, input logic [4:0] eb, input logic [4:0] em,
                         input logic [10:0] ma, input logic [10:0] mb,
                         input logic [4:0] diff, input logic ge,
                         input logic [3:0] ca, input logic [3:0] cb);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".SIGN_A"}, 32'(SIGN_A), 32'(sa));
    chk({tag, ".SIGN_B"}, 32'(SIGN_B), 32'(sb));
    chk({tag, ".EXP_A"}, 32'(IN_EXP_A_HALF), 32'(ea));
    chk({tag, ".EXP_B"}, 32'(IN_EXP_B_HALF), 32'(eb));
    chk({tag, ".EXP"}, 32'(IN_EXP_HALF), 32'(em));
    chk({tag, ".MANT_A"}, 32'(IN_MANT_A_HALF), 32'(ma));
    chk({tag, ".MANT_B"}, 32'(IN_MANT_B_HALF), 32'(mb));
    chk({tag, ".EXP_DIFF"}, 32'(EXP_DIFF), 32'(diff));
    chk({tag, ".A_GE_B"}, 32'(A_GE_B), 32'(ge));
    chk({tag, ".CLASS_A"}, 32'(CLASS_A), 32'(ca));
    chk({tag, ".CLASS_B"}, 32'(CLASS_B), 32'(cb));
  endtask

  // Send one pair into an empty pipeline and wait the two-cycle latency.
  task automatic send_one(input logic [15:0] a, input logic [15:0] b);
    in_valid = 1'b1;
    A = a;
    B = b;
    #2;
    chk("send.in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("send.lat1_out_valid", 32'(out_valid), 32'd0);
    tick();
  endtask

  // Stream operand k: A exponent k+1, fraction k*37+5; B fixed at 1.0.
  function automatic logic [15:0] pat_a(input int k);
    logic [9:0] f;
    logic [4:0] e;
    f = 10'(k * 37 + 5);
    e = 5'(k + 1);
    return {1'b0, e, f};
  endfunction

  function automatic logic [10:0] pat_mant(input int k);
    logic [9:0] f;
    f = 10'(k * 37 + 5);
    return {1'b1, f};
  endfunction

  initial begin
    int sent;
    int recv;
    int first_out;
    int stall_cnt;
    bit in_fire;
    bit out_fire;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    A         = 16'h0;
    B         = 16'h0;

    // Reset state
    repeat (2) tick();
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.MANT_A", 32'(IN_MANT_A_HALF), 32'd0);
    chk("rst.EXP_HALF", 32'(IN_EXP_HALF), 32'd0);
    chk("rst.CLASS_B", 32'(CLASS_B), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst.in_ready", 32'(in_ready), 32'd1);

    // 1.0 and 2.0
    send_one(16'h3C00, 16'h4000);
    chk_out("norm", 1'b0, 1'b0, 5'd15, 5'd16, 5'd16, 11'h400, 11'h400,
            5'd1, 1'b0, 4'b0000, 4'b0000);
    tick();
    chk("norm.drained", 32'(out_valid), 32'd0);

    // Negative subnormal vs +0
`ifdef FP16_UNPACK_DAZ_EN
    send_one(16'h8001, 16'h0000);
    chk_out("sub", 1'b1, 1'b0, 5'd1, 5'd1, 5'd1, 11'h000, 11'h000,
            5'd0, 1'b1, 4'b0001, 4'b0001);
`else
    send_one(16'h8001, 16'h0000);
    chk_out("sub", 1'b1, 1'b0, 5'd1, 5'd1, 5'd1, 11'h001, 11'h000,
            5'd0, 1'b1, 4'b0010, 4'b0001);
`endif
    tick();

    // qNaN vs -inf
    send_one(16'h7E00, 16'hFC00);
    chk_out("naninf", 1'b0, 1'b1, 5'd31, 5'd31, 5'd31, 11'h600, 11'h400,
            5'd0, 1'b1, 4'b1000, 4'b0100);
    tick();

    // A small and B large: A_GE_B=0, EXP_DIFF=29 (0x0400 has e=1, 0x7800 has e=30)
    send_one(16'h0400, 16'h7800);
    chk_out("wide", 1'b0, 1'b0, 5'd1, 5'd30, 5'd30, 11'h400, 11'h400,
            5'd29, 1'b0, 4'b0000, 4'b0000);
    tick();

    // Backpressure: 5 pairs, out_ready low for 4 cycles after the first output
    sent = 0;
    recv = 0;
    first_out = -1;
    stall_cnt = 0;
    for (int c = 0; c < 30 && recv < 5; c++) begin
      out_ready = !(first_out >= 0 && c > first_out && c <= first_out + 4);
      in_valid  = (sent < 5);
      A         = pat_a(sent);
      B         = 16'h3C00;
      #2;
      if (!out_ready) begin
        stall_cnt++;
        chk("bp.stall_in_ready", 32'(in_ready), 32'd0);
        chk("bp.stall_out_valid", 32'(out_valid), 32'd1);
        chk("bp.stall_hold", 32'(IN_MANT_A_HALF), 32'(exp_q.size() > 0 ? exp_q[0] : 11'h7FF));
      end
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      if (out_fire) begin
        if (first_out < 0) first_out = c;
        if (exp_q.size() == 0) chk("bp.unexpected_out", 32'd1, 32'd0);
        else chk("bp.order", 32'(IN_MANT_A_HALF), 32'(exp_q.pop_front()));
        recv++;
      end
      if (in_fire) begin
        exp_q.push_back(pat_mant(sent));
        sent++;
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp.recv", 32'(recv), 32'd5);
    chk("bp.stalls", 32'(stall_cnt), 32'd4);
    chk("bp.queue_empty", 32'(exp_q.size()), 32'd0);
    tick();
    chk("bp.no_dup", 32'(out_valid), 32'd0);

    // Full throughput: 8 pairs back to back, outputs on cycles 2..9
    for (int c = 0; c < 11; c++) begin
      in_valid = (c < 8);
      A        = pat_a(c + 10);
      B        = 16'h3C00;
      #2;
      if (c < 8) chk("tp.in_ready", 32'(in_ready), 32'd1);
      if (c >= 2 && c < 10) begin
        chk("tp.out_valid", 32'(out_valid), 32'd1);
        chk("tp.data", 32'(IN_MANT_A_HALF), 32'(pat_mant(c - 2 + 10)));
      end else begin
        chk("tp.idle", 32'(out_valid), 32'd0);
      end
      tick();
    end
    in_valid = 1'b0;

    // Asynchronous reset with two pairs in flight
    in_valid = 1'b1;
    A = 16'h4400;
    B = 16'hC400;
    tick();
    A = 16'h4800;
    tick();
    in_valid = 1'b0;
    chk("arst.pre_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.out_valid", 32'(out_valid), 32'd0);
    chk("arst.MANT_A", 32'(IN_MANT_A_HALF), 32'd0);
    chk("arst.EXP_A", 32'(IN_EXP_A_HALF), 32'd0);
    chk("arst.SIGN_B", 32'(SIGN_B), 32'd0);
    #3;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("arst.no_stale", 32'(out_valid), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
